// File: rtl/run_length_detector_if.sv
// Sample and detection bundle for run_length_detector.
// hit_cnt (and CNT_W) exist only when RLD_HIT_COUNT_EN is defined.
interface run_length_detector_if #(
   parameter int RW = 3
`ifdef RLD_HIT_COUNT_EN
   , parameter int CNT_W = 8
`endif
);
   logic          en;
   logic          w;
   logic [1:0]    z;
   logic [1:0]    hit;
   logic [RW-1:0] run_len;
`ifdef RLD_HIT_COUNT_EN
   logic [CNT_W-1:0] hit_cnt;

   modport master (output en, output w, input z, input hit, input run_len, input hit_cnt);
   modport slave  (input en, input w, output z, output hit, output run_len, output hit_cnt);
`else
   modport master (output en, output w, input z, input hit, input run_len);
   modport slave  (input en, input w, output z, output hit, output run_len);
`endif
endinterface

// File: rtl/run_length_detector.sv
// Flags runs of equal bits on w: z[0]/hit[0] for zeros, z[1]/hit[1] for ones.
// Define RLD_HIT_COUNT_EN to add the saturating hit_cnt output.
module run_length_detector #(
   parameter int ZERO_LEN = 4,
   parameter int ONE_LEN  = 4,
   parameter int MODE     = 0,
   parameter int CNT_W    = 8
) (
   input logic clk,
   input logic rst,
   run_length_detector_if.slave bus
);
   localparam int MAX_LEN = (ZERO_LEN > ONE_LEN) ? ZERO_LEN : ONE_LEN;
   localparam int RW      = $clog2(MAX_LEN + 1);
   localparam logic [RW-1:0] ZL      = RW'(ZERO_LEN);
   localparam logic [RW-1:0] OL      = RW'(ONE_LEN);
   localparam logic [RW-1:0] CNT_ONE = RW'(1);

   if (ZERO_LEN < 1 || ZERO_LEN > 255) begin : g_bad_zero_len
      $error("run_length_detector: ZERO_LEN must be 1..255");
   end
   if (ONE_LEN < 1 || ONE_LEN > 255) begin : g_bad_one_len
      $error("run_length_detector: ONE_LEN must be 1..255");
   end
   if (MODE != 0 && MODE != 1) begin : g_bad_mode
      $error("run_length_detector: MODE must be 0 or 1");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("run_length_detector: CNT_W must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, ZRUN, ORUN} state_t;

   state_t        state, state_n;
   logic [RW-1:0] cnt, cnt_n;
   logic [1:0]    z_q, hit_q, hit_n;

   function automatic logic [RW-1:0] advance(input logic [RW-1:0] c, input logic [RW-1:0] lim);
      if (c == lim) return (MODE == 0) ? lim : CNT_ONE;
      return c + CNT_ONE;
   endfunction

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      hit_n   = '0;
      if (bus.en) begin
         unique case (state)
            IDLE: begin
               state_n = bus.w ? ORUN : ZRUN;
               cnt_n   = CNT_ONE;
            end
            ZRUN: begin
               if (bus.w) begin
                  state_n = ORUN;
                  cnt_n   = CNT_ONE;
               end else begin
                  cnt_n = advance(cnt, ZL);
               end
            end
            ORUN: begin
               if (!bus.w) begin
                  state_n = ZRUN;
                  cnt_n   = CNT_ONE;
               end else begin
                  cnt_n = advance(cnt, OL);
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         endcase
         // A sticky run already sitting at its length is not a new detection.
         hit_n[0] = (state_n == ZRUN) && (cnt_n == ZL) && !(MODE == 0 && state == ZRUN && cnt == ZL);
         hit_n[1] = (state_n == ORUN) && (cnt_n == OL) && !(MODE == 0 && state == ORUN && cnt == OL);
      end
   end

   // z is registered from the next state, so it always equals the decode of state/cnt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         z_q   <= '0;
         hit_q <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         z_q   <= {(state_n == ORUN) && (cnt_n == OL), (state_n == ZRUN) && (cnt_n == ZL)};
         hit_q <= hit_n;
      end
   end

   assign bus.z       = z_q;
   assign bus.hit     = hit_q;
   assign bus.run_len = cnt;

`ifdef RLD_HIT_COUNT_EN
   logic [CNT_W-1:0] hit_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q <= '0;
      end else if (|hit_n && hit_cnt_q != '1) begin
         hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end
   end

   assign bus.hit_cnt = hit_cnt_q;
`endif
endmodule
